// File: rtl/spi_sckgen.sv
// spi_sckgen: SPI serial-clock and strobe generator.
// Runs one transfer of bit_len_i+1 bits per accepted start_i pulse in any
// CPOL/CPHA mode and emits registered sample_o/shift_o strobes aligned to the
// sck_o edges, so the shift register never decodes polarity or phase.
// Optional feature macro: SPI_SCKGEN_DELAY_EN adds a SETUP half-period before
// the first SCK edge (CS-to-SCK lead) and a HOLD half-period after the last
// edge before done_o. Without it the FSM is IDLE -> RUN -> IDLE.
//
// Handshake: start_i is a single-cycle request, accepted only when the block
// is enabled, idle (busy_o=0) and not presenting done_o in that same cycle;
// busy_o stays high from the cycle after acceptance until the done_o cycle.
// state_o exposes the FSM state for debug and checkers.
module spi_sckgen #(
  parameter int DIV_WIDTH = 16,
  parameter int LEN_WIDTH = 8
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 en_i,
  input  logic                 start_i,
  input  logic                 cpol_i,
  input  logic                 cpha_i,
  input  logic [DIV_WIDTH-1:0] clk_div_i,
  input  logic [LEN_WIDTH-1:0] bit_len_i,
  output logic                 busy_o,
  output logic                 sck_o,
  output logic                 sample_o,
  output logic                 shift_o,
  output logic                 last_o,
  output logic                 done_o,
  output logic [1:0]           state_o
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    RUN   = 2'd2,
    HOLD  = 2'd3
  } state_e;

  state_e               state_q, state_d;
  logic [DIV_WIDTH-1:0] cnt_q, cnt_d;
  // Counts edges already produced; one extra bit so 2*N edges fit.
  logic [LEN_WIDTH:0]   edge_q, edge_d;
  // Set after the final edge when no HOLD phase follows.
  logic                 fin_q, fin_d;
  logic                 sck_q, sck_d;
  logic                 sample_q, sample_d;
  logic                 shift_q, shift_d;
  logic                 last_q, last_d;
  logic                 done_q, done_d;
  logic                 cpol_q, cpol_d;
  logic                 cpha_q, cpha_d;
  logic [DIV_WIDTH-1:0] div_q, div_d;
  logic [LEN_WIDTH-1:0] len_q, len_d;

  logic tick;
  logic leading;
  logic final_edge;
  logic last_lead;

  // Half-period expiry and classification of the edge about to be produced.
  assign tick       = (cnt_q == '0);
  assign leading    = ~edge_q[0];
  assign final_edge = (edge_q == {len_q, 1'b1});
  assign last_lead  = (edge_q == {len_q, 1'b0});

  // Next-state logic: transfer sequencing, SCK toggling and strobe decode.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    edge_d   = edge_q;
    fin_d    = fin_q;
    sck_d    = sck_q;
    sample_d = 1'b0;
    shift_d  = 1'b0;
    last_d   = 1'b0;
    done_d   = 1'b0;
    cpol_d   = cpol_q;
    cpha_d   = cpha_q;
    div_d    = div_q;
    len_d    = len_q;

    if (!en_i) begin
      // Abort: drop straight back to idle with SCK at the live idle level.
      state_d = IDLE;
      sck_d   = cpol_i;
      fin_d   = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          sck_d = cpol_i;
          if (start_i && !done_q) begin
            cpol_d = cpol_i;
            cpha_d = cpha_i;
            div_d  = clk_div_i;
            len_d  = bit_len_i;
            cnt_d  = clk_div_i;
            edge_d = '0;
            fin_d  = 1'b0;
`ifdef SPI_SCKGEN_DELAY_EN
            state_d = SETUP;
`else
            state_d = RUN;
`endif
          end
        end

        SETUP: begin
          if (tick) begin
            cnt_d   = div_q;
            state_d = RUN;
          end else begin
            cnt_d = cnt_q - DIV_WIDTH'(1);
          end
        end

        RUN: begin
          if (fin_q) begin
            state_d = IDLE;
            done_d  = 1'b1;
            fin_d   = 1'b0;
          end else if (tick) begin
            cnt_d  = div_q;
            sck_d  = ~sck_q;
            edge_d = edge_q + (LEN_WIDTH+1)'(1);
            if (cpha_q) begin
              shift_d  = leading;
              sample_d = ~leading;
              last_d   = ~leading & final_edge;
            end else begin
              sample_d = leading;
              shift_d  = ~leading & ~final_edge;
              last_d   = leading & last_lead;
            end
            if (final_edge) begin
`ifdef SPI_SCKGEN_DELAY_EN
              state_d = HOLD;
`else
              fin_d = 1'b1;
`endif
            end
          end else begin
            cnt_d = cnt_q - DIV_WIDTH'(1);
          end
        end

        HOLD: begin
          if (tick) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end else begin
            cnt_d = cnt_q - DIV_WIDTH'(1);
          end
        end

        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  // State, counters, snapshot and registered outputs.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      edge_q   <= '0;
      fin_q    <= 1'b0;
      sck_q    <= 1'b0;
      sample_q <= 1'b0;
      shift_q  <= 1'b0;
      last_q   <= 1'b0;
      done_q   <= 1'b0;
      cpol_q   <= 1'b0;
      cpha_q   <= 1'b0;
      div_q    <= '0;
      len_q    <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      edge_q   <= edge_d;
      fin_q    <= fin_d;
      sck_q    <= sck_d;
      sample_q <= sample_d;
      shift_q  <= shift_d;
      last_q   <= last_d;
      done_q   <= done_d;
      cpol_q   <= cpol_d;
      cpha_q   <= cpha_d;
      div_q    <= div_d;
      len_q    <= len_d;
    end
  end

  assign busy_o   = (state_q != IDLE);
  assign sck_o    = sck_q;
  assign sample_o = sample_q;
  assign shift_o  = shift_q;
  assign last_o   = last_q;
  assign done_o   = done_q;
  assign state_o  = state_q;

endmodule

// File: tb/tb_spi_sckgen.sv
// tb_spi_sckgen: directed bench for spi_sckgen (default parameters).
// Inputs are driven 1 ns after the falling edge; a monitor samples outputs on
// the falling edge and accumulates per-transfer statistics.
module tb_spi_sckgen;

`ifdef SPI_SCKGEN_DELAY_EN
  localparam int DLY = 1;
`else
  localparam int DLY = 0;
`endif

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b0;
  logic        en_i = 1'b1;
  logic        start_i = 1'b0;
  logic        cpol_i = 1'b0;
  logic        cpha_i = 1'b0;
  logic [15:0] clk_div_i = '0;
  logic [7:0]  bit_len_i = '0;
  logic        busy_o, sck_o, sample_o, shift_o, last_o, done_o;
  logic [1:0]  state_o;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  logic [31:0] exp_q[$];

  spi_sckgen dut (
    .clk_i(clk_i), .rst_i(rst_i), .en_i(en_i), .start_i(start_i),
    .cpol_i(cpol_i), .cpha_i(cpha_i), .clk_div_i(clk_div_i),
    .bit_len_i(bit_len_i), .busy_o(busy_o), .sck_o(sck_o),
    .sample_o(sample_o), .shift_o(shift_o), .last_o(last_o),
    .done_o(done_o), .state_o(state_o)
  );

  // Clock and cycle counter.
  always #5 clk_i = ~clk_i;
  always @(posedge clk_i) cyc <= cyc + 1;

  // Monitor state, cleared whenever clr_req toggles.
  logic clr_req = 1'b0;
  logic clr_ack = 1'b0;
  logic m_cpol = 1'b0;
  logic sck_prev = 1'b0;
  int tog, smp, shf, smp_lead, shf_lead, lst, lst_idx, lst_bad, dn;
  int first_t, last_t, gmin, gmax, done_t;
  logic sck_at_done, busy_at_done;

  always @(negedge clk_i) begin
    if (clr_req != clr_ack) begin
      clr_ack = clr_req;
      tog = 0; smp = 0; shf = 0; smp_lead = 0; shf_lead = 0;
      lst = 0; lst_idx = 0; lst_bad = 0; dn = 0;
      first_t = 0; last_t = 0; gmin = 99999; gmax = 0; done_t = 0;
      sck_at_done = 1'b0; busy_at_done = 1'b1;
      sck_prev = m_cpol;
    end
    if (busy_o && sck_o != sck_prev) begin
      if (tog == 0) first_t = cyc;
      else begin
        if (cyc - last_t < gmin) gmin = cyc - last_t;
        if (cyc - last_t > gmax) gmax = cyc - last_t;
      end
      last_t = cyc;
      tog++;
    end
    if (sample_o) begin
      smp++;
      if (sck_o != m_cpol) smp_lead++;
    end
    if (shift_o) begin
      shf++;
      if (sck_o != m_cpol) shf_lead++;
    end
    if (last_o) begin
      lst++;
      lst_idx = smp;
      if (!sample_o) lst_bad++;
    end
    if (done_o) begin
      dn++;
      done_t = cyc;
      sck_at_done = sck_o;
      busy_at_done = busy_o;
    end
    sck_prev = sck_o;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Launch a transfer and wait for done. chg>0 changes divider, polarity and
  // length that many cycles into the transfer. e_d is the half-period D.
  task automatic do_xfer(input logic [15:0] div, input logic [7:0] len,
                         input logic cpol, input logic cpha, input int chg,
                         input int e_tog, input int e_smp, input int e_shf,
                         input int e_d);
    int t0;
    @(negedge clk_i); #1;
    clk_div_i = div; bit_len_i = len; cpol_i = cpol; cpha_i = cpha;
    start_i = 1'b1; m_cpol = cpol; clr_req = ~clr_req; t0 = cyc + 1;
    @(negedge clk_i); #1;
    start_i = 1'b0;
    check("busy_t0p1", busy_o, 1);
    for (int k = 1; k < 3000 && dn == 0; k++) begin
      if (k == chg) begin
        clk_div_i = '0; cpol_i = ~cpol; bit_len_i = len + 8'd4;
      end
      @(negedge clk_i); #1;
    end
    repeat (4) @(negedge clk_i);
    #1;
    exp_q.push_back(e_tog);
    exp_q.push_back(e_smp);
    exp_q.push_back(e_shf);
    exp_q.push_back(1);
    exp_q.push_back(e_smp);
    check("toggles", tog, exp_q.pop_front());
    check("samples", smp, exp_q.pop_front());
    check("shifts", shf, exp_q.pop_front());
    check("last_cnt", lst, exp_q.pop_front());
    check("last_idx", lst_idx, exp_q.pop_front());
    check("last_alone", lst_bad, 0);
    check("done_cnt", dn, 1);
    check("smp_lead", smp_lead, cpha ? 0 : e_smp);
    check("shf_lead", shf_lead, cpha ? e_shf : 0);
    check("first_tog", first_t - t0, e_d * (1 + DLY));
    check("gap_min", gmin, e_d);
    check("gap_max", gmax, e_d);
    check("done_lat", done_t - last_t, (DLY != 0) ? e_d : 1);
    check("sck_end", sck_at_done, cpol);
    check("busy_done", busy_at_done, 0);
  endtask

  initial begin
    // Reset values, then sck follows cpol_i on the first clock after release.
    cpol_i = 1'b1;
    #2 rst_i = 1'b1;
    #2;
    check("rst_outs", {sck_o, busy_o, sample_o, shift_o, last_o, done_o}, 0);
    check("rst_state", state_o, 0);
    repeat (2) @(negedge clk_i);
    #1 rst_i = 1'b0;
    @(negedge clk_i); #1;
    check("rel_sck", sck_o, 1);
    check("rel_busy", busy_o, 0);

    // Basic mode 0, fastest clock.
    do_xfer(16'd0, 8'd7, 1'b0, 1'b0, 0, 16, 8, 7, 1);
    // Mode 3, divider 3.
    do_xfer(16'd3, 8'd3, 1'b1, 1'b1, 0, 8, 4, 4, 4);
    // Mid-transfer input changes are ignored.
    do_xfer(16'd2, 8'd1, 1'b0, 1'b0, 2, 4, 2, 1, 3);
    // Maximum length: 256 bits, 512 edges.
    do_xfer(16'd0, 8'd255, 1'b0, 1'b1, 0, 512, 256, 256, 1);

    // Abort after the 5th edge.
    @(negedge clk_i); #1;
    clk_div_i = 16'd1; bit_len_i = 8'd7; cpol_i = 1'b1; cpha_i = 1'b0;
    start_i = 1'b1; m_cpol = 1'b1; clr_req = ~clr_req;
    @(negedge clk_i); #1;
    start_i = 1'b0;
    for (int k = 0; k < 200 && tog < 5; k++) begin
      @(negedge clk_i); #1;
    end
    en_i = 1'b0;
    @(negedge clk_i); #1;
    check("abort_busy", busy_o, 0);
    check("abort_sck", sck_o, 1);
    check("abort_strb", {sample_o, shift_o, last_o, done_o}, 0);
    check("abort_state", state_o, 0);
    en_i = 1'b1;
    repeat (20) @(negedge clk_i);
    #1;
    check("abort_nodone", dn, 0);
    do_xfer(16'd0, 8'd2, 1'b0, 1'b1, 0, 6, 3, 3, 1);

    // start_i while busy and on the done_o cycle are both ignored.
    @(negedge clk_i); #1;
    clk_div_i = 16'd1; bit_len_i = 8'd1; cpol_i = 1'b0; cpha_i = 1'b0;
    start_i = 1'b1; m_cpol = 1'b0; clr_req = ~clr_req;
    @(negedge clk_i); #1;
    start_i = 1'b0;
    repeat (2) @(negedge clk_i);
    #1 start_i = 1'b1;
    @(negedge clk_i); #1;
    start_i = 1'b0;
    for (int k = 0; k < 200 && dn == 0; k++) begin
      @(negedge clk_i); #1;
    end
    check("done_seen", done_o, 1);
    start_i = 1'b1;
    @(negedge clk_i); #1;
    start_i = 1'b0;
    check("ign_busy", busy_o, 0);
    check("ign_state", state_o, 0);
    repeat (12) @(negedge clk_i);
    #1;
    check("ign_done_cnt", dn, 1);
    check("ign_toggles", tog, 4);

    // Asynchronous reset in the middle of RUN.
    @(negedge clk_i); #1;
    clk_div_i = 16'd2; bit_len_i = 8'd7; cpol_i = 1'b1; cpha_i = 1'b0;
    start_i = 1'b1; m_cpol = 1'b1; clr_req = ~clr_req;
    @(negedge clk_i); #1;
    start_i = 1'b0;
    repeat (10) @(negedge clk_i);
    #1 rst_i = 1'b1;
    #1;
    check("arst_outs", {sck_o, busy_o, sample_o, shift_o, last_o, done_o}, 0);
    check("arst_state", state_o, 0);
    repeat (2) @(negedge clk_i);
    #1 rst_i = 1'b0;
    @(negedge clk_i); #1;
    check("arst_rel_sck", sck_o, 1);
    check("arst_rel_busy", busy_o, 0);
    check("arst_rel_state", state_o, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/spi_sckgen.md
# spi_sckgen

Parametrised SPI serial-clock and strobe generator, the successor to the fixed-width SPI clock generator in the SPI master datapath. It runs one complete transfer of a programmable bit count, either 1 to 2^LEN_WIDTH bits, from a single `start_i` pulse. It supports all four CPOL/CPHA modes and emits registered `sample_o`/`shift_o` strobes aligned to `sck_o` edges, so the shift register does not need to decode polarity or phase. It sits between the SPI register file (divider, mode, length) and the shift-register/chip-select logic.

## Interface
- `DIV_WIDTH`, default 16: width of the divider; half-period is `clk_div_i+1` clk_i cycles.
- `LEN_WIDTH`, default 8: width of the bit-count field.
- `clk_i`  in  1  system clock; all logic on the rising edge.
- `rst_i`  in  1  asynchronous, active-high reset.
- `en_i`  in  1  block enable; low aborts any transfer at once.
- `start_i`  in  1  single-cycle transfer request; ignored while `busy_o`=1 or `en_i`=0.
- `cpol_i`  in  1  SCK idle level.
- `cpha_i`  in  1  0: sample on leading edge; 1: shift on leading edge.
- `clk_div_i`  in  DIV_WIDTH  half-period minus one.
- `bit_len_i`  in  LEN_WIDTH  bits per transfer minus one.
- `busy_o`  out  1  transfer in progress.
- `sck_o`  out  1  serial clock, registered.
- `sample_o`  out  1  one-cycle strobe: capture MISO.
- `shift_o`  out  1  one-cycle strobe: advance MOSI.
- `last_o`  out  1  qualifies the final `sample_o` pulse.
- `done_o`  out  1  one-cycle pulse at normal completion.

## Operation
- FSM states: IDLE, SETUP, RUN, HOLD; SETUP and HOLD exist only per Configuration.
- IDLE: `sck_o` follows registered `cpol_i`. The half-period counter and edge counter are held.
- On an accepted `start_i`, snapshot `cpol_i`, `cpha_i`, `clk_div_i`, `bit_len_i`. Later input changes do not affect the transfer in flight.
- Half-period counter: loads the divider snapshot and decrements. At zero it reloads and produces a tick.
- In RUN, each tick toggles `sck_o` and increments the edge counter (LEN_WIDTH+1 bits). RUN ends after 2·N edges, where N = `bit_len_i`+1.
- Odd edges are leading edges; even edges are trailing edges.
- CPHA=0:
  - `sample_o` fires on every leading edge (N pulses).
  - `shift_o` fires on every trailing edge except the last (N-1 pulses).
- CPHA=1:
  - `shift_o` fires on every leading edge (N pulses).
  - `sample_o` fires on every trailing edge (N pulses).
- `last_o` is high only together with the N-th `sample_o` pulse.
- `sck_o` ends the transfer at the snapshot CPOL level.
- `done_o` pulses once at completion, and `busy_o` deasserts in the same cycle.
- Abort: when `en_i`=0 in any state, the next cycle has state IDLE, `sck_o`=`cpol_i`, all strobes 0, `busy_o`=0, and no `done_o`.
- A `start_i` arriving in the same cycle `done_o` is high is ignored. A new start requires `busy_o`=0 at sampling.
- Reset values:
  - `sck_o`=0, `busy_o`=0, `sample_o`=0, `shift_o`=0, `last_o`=0, `done_o`=0.
  - State IDLE, counters 0.
  - `sck_o` takes `cpol_i` on the first clock after reset release.

## Timing
- Let `start_i` be sampled at edge T0 and D = `clk_div_i`+1.
- `busy_o` is high from T0+1.
- First `sck_o` toggle:
  - Without the delay macro: at T0+D.
  - With the delay macro: at T0+2D.
- Each later toggle follows every D cycles.
- Strobes and `last_o` are registered in the same cycle that `sck_o` shows the new level.
- Completion, with final edge at TL:
  - Without the delay macro: `done_o` at TL+1.
  - With the delay macro: `done_o` at TL+D.
- `clk_div_i`=0 gives SCK = clk_i/2, with a strobe every cycle; there are no special cases.
- `bit_len_i` at maximum gives 2^LEN_WIDTH bits. The edge counter must not wrap before 2·N.

## Configuration
- `SPI_SCKGEN_DELAY_EN` defined:
  - SETUP inserts one half-period (D cycles) between start and the first SCK edge, as CS-to-SCK lead time.
  - HOLD inserts D cycles after the last edge before `done_o`.
- Not defined: SETUP and HOLD are removed, and the FSM goes IDLE→RUN→IDLE.

## Test plan
- Div=0, len=7, CPOL=0, CPHA=0 (no macro): 16 toggles on consecutive cycles, 8 `sample_o`, 7 `shift_o`, `last_o` on the 8th sample, `done_o` at TL+1, `sck_o` ends at 0.
- Div=3, len=3, CPOL=1, CPHA=1 (macro on): first toggle at T0+8, toggles every 4 cycles, 4 shifts on falling edges, 4 samples on rising edges, `done_o` 4 cycles after the 8th edge, `sck_o` ends at 1.
- Change `clk_div_i`/`cpol_i` mid-transfer (div 2→0): edge spacing stays 3 cycles and the polarity is unchanged until done.
- Drop `en_i` after the 5th edge: next cycle `busy_o`=0, `sck_o`=CPOL, no `done_o`; a new start then runs a full transfer.
- `start_i` pulsed while busy and on the `done_o` cycle: both are ignored; exactly one `done_o` per accepted start.
- Assert `rst_i` mid-RUN, asynchronously: all outputs are 0 immediately; after release `sck_o`=`cpol_i` and the block is IDLE.
